spi_mem_master: RTL and testbench

SPI master that drives the SPI memory slave's sclk/cs/mosi pins and samples its miso pin. It converts a single-cycle request (address, read/write, write data) into one 16-bit mode-0 SPI frame. Frame layout: byte 0 = {addr[6:0], rw}; byte 1 = write data, or read data from the slave. It sits between a host FSM or test driver on the FPGA clock and the memory slave's pins.

---
 rtl/spi_mem_master_if.sv | 30 +++
 rtl/spi_mem_master.sv | 186 ++++++++++++++++++
 tb/tb_spi_mem_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_master_if.sv
// Host-side request/response signals and SPI pins of spi_mem_master, bundled
// so the master and its driver/slave model share one connection.
interface spi_mem_master_if;
  // Handshake: start is a one-cycle strobe taken only while the master is idle
  // (busy=0); rw/addr/wdata must be valid in that same cycle. busy rises the
  // cycle after accept, done pulses once per completed frame, and rdata holds
  // the last read result.
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [2:0] dbg_state;

  modport master (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, sclk, cs, mosi, dbg_state
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, sclk, cs, mosi, dbg_state
  );
endinterface

// File: rtl/spi_mem_master.sv
// Mode-0 SPI master: turns one host request into a 16-bit frame
// {addr, rw, data}, MSB first, and returns the read byte on done.
module spi_mem_master #(
  parameter int HALF_PERIOD = 8,
  parameter int CS_SETUP    = 8,
  parameter int CS_HOLD     = 8,
  parameter int CS_GAP      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_master_if.master  bus
);

  localparam int MAX_AB = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HP_LAST    = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  phase_last;
  logic           phase_end;
  logic [3:0]     bit_q, bit_d;
  logic [15:0]    frame_q, frame_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           sclk_q, sclk_d;
  logic           cs_q, cs_d;
  logic           mosi_q, mosi_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      shreg_q <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      shreg_q <= shreg_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Each timed state runs its phase counter from 0 up to its own last value.
  always_comb begin
    phase_last = '0;
    case (state_q)
      S_SETUP:       phase_last = SETUP_LAST;
      S_HIGH, S_LOW: phase_last = HP_LAST;
      S_HOLD:        phase_last = HOLD_LAST;
      S_GAP:         phase_last = GAP_LAST;
      default:       phase_last = '0;
    endcase
  end

  assign phase_end = (cnt_q == phase_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    frame_d = frame_q;
    shreg_d = shreg_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          frame_d = {bus.addr, bus.rw, bus.wdata};
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = bus.addr[6];
          bit_d   = 4'd15;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end

      // Sample at the very end of the high phase so the slave's delayed
      // falling-edge update of miso has long settled.
      S_HIGH: begin
        if (phase_end) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (!bit_q[3]) begin
            shreg_d = {shreg_q[6:0], bus.miso};
          end
          if (bit_q == 4'd0) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q - 4'd1;
            mosi_d  = frame_q[bit_q - 4'd1];
            state_d = S_LOW;
          end
        end
      end

      S_LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end

      S_HOLD: begin
        if (phase_end) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          if (frame_q[8]) begin
            rdata_d = shreg_q;
          end
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (phase_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.sclk      = sclk_q;
  assign bus.cs        = cs_q;
  assign bus.mosi      = mosi_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed plus randomized bench for spi_mem_master with a pin-level SPI
// memory slave model and a word-level reference of memory contents.
module tb_spi_mem_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_mem_master_if bus ();

  spi_mem_master #(
    .HALF_PERIOD(8), .CS_SETUP(8), .CS_HOLD(8), .CS_GAP(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- clock/reset helpers and counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- pin monitor and SPI slave model ----------------
  logic [7:0]  slave_mem [128] = '{default: 8'h00};
  logic [15:0] cap = '0;
  logic [15:0] last_frame = '0;
  int          rise_cnt = 0;
  int          last_rises = 0;
  int          done_total = 0;
  int          viol = 0;
  int          cs_lo_run = 0, cs_hi_run = 1000, last_cs_low = 0, gap_min = 1000;
  int          hi_run = 0, lo_run = 0;
  int          hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
  bit          seen_fall = 1'b0;
  bit          slave_rd = 1'b0;
  logic [7:0]  slave_byte = '0;
  int          pend = 0;
  logic        pend_bit = 1'b0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rise_cnt  = 0;
      seen_fall = 1'b0;
      slave_rd  = 1'b0;
      pend      = 0;
      bus.miso  = 1'b0;
      cs_hi_run = 1000;
    end else begin
      if (pend != 0) begin
        pend--;
        if (pend == 0) bus.miso = pend_bit;
      end
      if (bus.done === 1'b1) begin
        done_total++;
        if (!(bus.cs === 1'b1 && prev_cs === 1'b0)) viol++;
      end
      if (prev_sclk === 1'b1 && bus.sclk === 1'b1 && bus.mosi !== prev_mosi) viol++;
      if (bus.cs === 1'b1 && prev_cs === 1'b1 && bus.sclk !== prev_sclk) viol++;

      if (bus.cs === 1'b0 && prev_cs === 1'b1) begin
        if (cs_hi_run < gap_min) gap_min = cs_hi_run;
        cs_lo_run = 1;
        rise_cnt  = 0;
        cap       = '0;
        seen_fall = 1'b0;
      end else if (bus.cs === 1'b0) begin
        cs_lo_run++;
      end

      if (bus.sclk === 1'b1 && prev_sclk === 1'b0 && bus.cs === 1'b0) begin
        if (seen_fall) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        hi_run = 1;
        cap = {cap[14:0], bus.mosi};
        rise_cnt++;
        if (rise_cnt == 8) begin
          slave_rd   = cap[0];
          slave_byte = slave_mem[cap[7:1]];
        end
      end else if (bus.sclk === 1'b1) begin
        hi_run++;
      end

      // Slave shifts out its byte 3 clocks after each falling edge of byte 1.
      if (bus.sclk === 1'b0 && prev_sclk === 1'b1 && bus.cs === 1'b0) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_run    = 1;
        seen_fall = 1'b1;
        if (slave_rd && rise_cnt >= 8 && rise_cnt <= 15) begin
          pend       = 3;
          pend_bit   = slave_byte[7];
          slave_byte = {slave_byte[6:0], 1'b0};
        end
      end else if (bus.sclk === 1'b0 && seen_fall) begin
        lo_run++;
      end

      if (bus.cs === 1'b1 && prev_cs === 1'b0) begin
        last_cs_low = cs_lo_run;
        last_frame  = cap;
        last_rises  = rise_cnt;
        if (rise_cnt == 16 && !cap[8]) slave_mem[cap[15:9]] = cap[7:0];
        slave_rd  = 1'b0;
        bus.miso  = 1'b0;
        cs_hi_run = 1;
      end else if (bus.cs === 1'b1) begin
        cs_hi_run++;
      end
    end
    prev_sclk = bus.sclk;
    prev_cs   = bus.cs;
    prev_mosi = bus.mosi;
  end

  // ---------------- reference model and driver tasks ----------------
  logic [7:0] ref_mem [128] = '{default: 8'h00};
  logic [7:0] ref_rdata = 8'h00;

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) check({tag, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d, input bit inject);
    int lat, d0;
    bit inj;
    logic [15:0] exp_frame;
    wait_idle("pre_frame");
    d0 = done_total;
    bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = d;
    tick();
    bus.start = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    lat = 1;
    inj = 1'b0;
    while (bus.done !== 1'b1 && lat < 600) begin
      if (inject && !inj && rise_cnt == 6) begin
        bus.start = 1'b1; bus.rw = ~r; bus.addr = ~a; bus.wdata = ~d;
        inj = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      lat++;
    end
    exp_frame = {a, r, d};
    if (r) ref_rdata = ref_mem[a];
    else   ref_mem[a] = d;
    check("latency", 32'(lat), 32'd265);
    check("rdata", 32'(bus.rdata), 32'(ref_rdata));
    check("sclk_rises", 32'(last_rises), 32'd16);
    check("mosi_frame", 32'(last_frame), 32'(exp_frame));
    check("cs_low_width", 32'(last_cs_low), 32'd264);
    if (inject) begin
      tick();
      bus.start = 1'b1; bus.rw = ~r; bus.addr = ~a;
      tick();
      bus.start = 1'b0;
    end
    wait_idle("post_frame");
    check("done_count", 32'(done_total - d0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    logic        r;
    logic [6:0]  a;
    logic [7:0]  d;
    int          d0, guard;

    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0; bus.miso = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_cs", 32'(bus.cs), 32'd1);
    check("reset_sclk", 32'(bus.sclk), 32'd0);
    check("reset_mosi", 32'(bus.mosi), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_frame(1'b0, 7'h12, 8'h5A, 1'b0);
    check("slave_wrote_5a", 32'(slave_mem[7'h12]), 32'h5A);
    run_frame(1'b0, 7'h12, 8'hC3, 1'b0);
    run_frame(1'b1, 7'h12, 8'h00, 1'b0);
    check("read_c3", 32'(bus.rdata), 32'hC3);

    // Starts mid-frame and during GAP must be ignored; next frame starts on the first idle cycle.
    run_frame(1'b0, 7'h33, 8'(($urandom_range(0, 255))), 1'b1);
    run_frame(1'b1, 7'h33, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom_range(0, 255));
      run_frame(r, a, d, 1'b0);
    end

    // Reset in the middle of a read's high phase.
    wait_idle("pre_reset");
    d0 = done_total;
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 7'h12; bus.wdata = 8'h00;
    tick();
    bus.start = 1'b0;
    guard = 0;
    while (!(rise_cnt == 12 && bus.sclk === 1'b1) && guard < 400) begin
      tick();
      guard++;
    end
    check("reset_wait_bit", 32'(rise_cnt), 32'd12);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    ref_rdata = 8'h00;
    check("midreset_cs", 32'(bus.cs), 32'd1);
    check("midreset_sclk", 32'(bus.sclk), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_rdata", 32'(bus.rdata), 32'd0);
    repeat (3) tick();
    #1 rst_n = 1'b1;
    repeat (20) tick();
    check("midreset_no_done", 32'(done_total - d0), 32'd0);
    a = 7'($urandom_range(0, 127));
    d = 8'($urandom_range(0, 255));
    run_frame(1'b0, a, d, 1'b0);
    run_frame(1'b1, a, 8'h00, 1'b0);

    run_frame(1'b0, 7'h7F, 8'hFF, 1'b0);
    run_frame(1'b1, 7'h7F, 8'h00, 1'b0);
    check("read_ff", 32'(bus.rdata), 32'hFF);

    check("sclk_high_min", 32'(hi_min), 32'd8);
    check("sclk_high_max", 32'(hi_max), 32'd8);
    check("sclk_low_min", 32'(lo_min), 32'd8);
    check("sclk_low_max", 32'(lo_max), 32'd8);
    check("cs_gap_ge_8", 32'(gap_min >= 8), 32'd1);
    check("pin_protocol_violations", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
